serial_add_ctrl: RTL
====================

Name: serial_add_ctrl

Overview:
- Bit-serial adder/subtractor controller that time-shares one 1-bit full-adder cell across a WIDTH-bit operation, one bit per clock, LSB first.
- Latches operands on a start handshake and sequences the cell through a bit counter and carry register.
- Presents the registered result with a one-cycle done pulse.
- Sits between the team's control logic and the 1-bit full-adder datapath as its sequencer.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 2..32)
CNT_W, $clog2(WIDTH), bit-counter width (derived; never overridden)

Ports:
clk    input   1      system clock, rising-edge
rst_n  input   1      asynchronous active-low reset
start  input   1      request a new operation; sampled only in IDLE
sub    input   1      0 = a+b+cin, 1 = a-b (b inverted, cin forced 1); sampled with start
a      input   WIDTH  operand A; sampled with start
b      input   WIDTH  operand B; sampled with start
cin    input   1      carry-in for add; ignored when sub=1
busy   output  1      high while in RUN or DONE
done   output  1      one-cycle pulse when result valid
sum    output  WIDTH  result; holds until next completion
cout   output  1      carry out of MSB (sub: 1 = no borrow)
ovf    output  1      signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n low, any time, including mid-operation):
  - State returns to IDLE immediately.
  - busy=0, done=0, sum=0, cout=0, ovf=0.
  - Internal shift registers, counter and carry are cleared.
  - Any partial operation is discarded.
- IDLE:
  - start=1 at an edge: latch a into the A shift register, and b (or ~b when sub=1) into the B shift register.
  - Load the carry register with cin (or 1 when sub=1).
  - Clear cnt to 0 and go to RUN.
  - start=0: remain in IDLE.
- RUN:
  - Each edge: the full-adder cell inputs are A_sr[0], B_sr[0] and carry.
  - The cell sum bit shifts into the MSB of the result shift register; A_sr and B_sr shift right by 1; carry <= cell carry; cnt <= cnt+1.
  - When cnt==WIDTH-2, capture the current carry as c_msb_in (carry into the MSB).
  - When cnt==WIDTH-1, complete the last bit and go to DONE.
  - On that same edge: sum <= final result register, cout <= cell carry, ovf <= c_msb_in XOR cell carry.
- DONE:
  - done=1 for exactly this one cycle, then unconditionally IDLE.
- Latency:
  - start sampled at edge T0 → RUN occupies edges T1..TWIDTH → done high in the cycle following edge TWIDTH (WIDTH+1 cycles after start).
  - Throughput is one operation per WIDTH+2 cycles.
- start while busy (RUN or DONE): ignored, with no queuing; the operand inputs may change freely.
- sum/cout/ovf:
  - Change only on the completion edge.
  - Stable otherwise, including during a subsequent RUN.
- Arithmetic:
  - Modulo 2^WIDTH.
  - For sub, cout=1 means a>=b (unsigned); a result wrapping negative gives cout=0.
- No combinational path from any input to any output; all outputs are registered.

Decomposition:
- Package serial_add_pkg: state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
- One sub-module: full_adder_cell (inputs a, b, ci; outputs s, co).
  - s = a^b^ci, co = majority(a, b, ci).
  - Exactly one instance, driven from the shift registers.

Test Plan (WIDTH=8):
1. a=8'h35, b=8'h4A, cin=0, sub=0, start pulsed → done exactly 9 cycles after the start edge; sum=8'h7F, cout=0, ovf=0; busy high for 9 cycles.
2. a=8'hFF, b=8'h01, cin=0, add → sum=8'h00, cout=1, ovf=0; then a=8'h7F, b=8'h01 → sum=8'h80, cout=0, ovf=1.
3. sub=1: a=8'h10, b=8'h20 → sum=8'hF0, cout=0; a=8'h20, b=8'h10 → sum=8'h10, cout=1, ovf=0; a=8'h80, b=8'h01 → sum=8'h7F, ovf=1.
4. Start a=8'h01, b=8'h01. At cycle 3, re-pulse start with a=8'hAA, b=8'h55 → second request ignored; result sum=8'h02. The sum output holds its prior value until the completion edge.
5. Start a=8'hF0, b=8'h0F; assert rst_n=0 asynchronously at cycle 4 (between edges) → busy, done, sum, cout and ovf go to 0 immediately. After release, a new start (a=8'h03, b=8'h04, cin=1) yields sum=8'h08 with normal latency.
6. Back-to-back starts held high continuously → a new operation begins every 10 cycles; done pulses each last exactly 1 cycle; no start is accepted in DONE.

Source files
------------

// File: rtl/serial_add_pkg.sv
// serial_add_pkg
//   Shared definitions for the bit-serial adder/subtractor sequencer.
//   state_t : sequencer state encoding (IDLE / RUN / DONE). The fourth code
//             (2'd3) has no name and is steered back to IDLE by the sequencer.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell
//   Single-bit full adder shared across every bit position of a serial
//   operation.
//   Ports:
//     a, b, ci : operand bits and carry in
//     s        : sum bit (a ^ b ^ ci)
//     co       : carry out (majority of a, b, ci)
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Bit-serial adder/subtractor sequencer. Operands are latched on start,
//   then one bit per clock (LSB first) is pushed through a single
//   full_adder_cell. The finished result is presented with a one-cycle done
//   pulse and held until the next completion.
//   Ports:
//     clk, rst_n : clock (rising edge), asynchronous active-low reset
//     start      : request an operation; only sampled in IDLE
//     sub        : 0 = a + b + cin, 1 = a - b
//     a, b, cin  : operands and carry-in, sampled with start
//     busy       : high in RUN and DONE
//     done       : one-cycle pulse when sum/cout/ovf are updated
//     sum        : registered result (modulo 2^WIDTH)
//     cout       : carry out of MSB (for subtract: 1 = no borrow)
//     ovf        : signed overflow
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   res_sr;
    logic [WIDTH-1:0]   res_nxt;
    logic               carry;
    logic               c_msb_in;
    logic               fa_s;
    logic               fa_co;
    logic               last_bit;
    logic               msb_next;

    full_adder_cell u_fa (
        .a  (a_sr[0]),
        .b  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    // The cell's carry out while processing bit WIDTH-2 is the carry into the MSB.
    assign msb_next = (cnt == CNT_W'(WIDTH - 2));
    // Result bits enter at the top so that after WIDTH shifts bit 0 sits at the LSB.
    assign res_nxt  = {fa_s, res_sr[WIDTH-1:1]};

    assign busy = (state == ST_RUN) || (state == ST_DONE);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (last_bit) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            carry    <= 1'b0;
            c_msb_in <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        // Subtract as a + ~b + 1.
                        b_sr  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    res_sr <= res_nxt;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= fa_co;
                    cnt    <= cnt + 1'b1;
                    if (msb_next) begin
                        c_msb_in <= fa_co;
                    end
                    if (last_bit) begin
                        sum  <= res_nxt;
                        cout <= fa_co;
                        ovf  <= c_msb_in ^ fa_co;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
